// File: rtl/crossbar_rr_nxm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : crossbar_rr_nxm
// Function : registered N_MM-to-N_CPU crossbar, one transfer per clock.
//            Define XBAR_RR_EN for a round-robin scheduler; otherwise fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module crossbar_rr_nxm #(
  parameter int N_MM   = 4,
  parameter int N_CPU  = 4,
  parameter int DATA_W = 8,
  parameter int MM_W   = $clog2(N_MM),
  parameter int CPU_W  = $clog2(N_CPU)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MM*DATA_W-1:0]  mm_data,
  input  logic [N_MM*CPU_W-1:0]   mm_dest,
  input  logic [N_MM-1:0]         mm_valid,
  output logic [N_MM-1:0]         mm_ready,
  output logic [N_CPU*DATA_W-1:0] cpu_data,
  output logic [N_CPU-1:0]        cpu_valid,
  input  logic [N_CPU-1:0]        cpu_ready,
  output logic [MM_W-1:0]         grant,
  output logic                    grant_vld
);

  logic [N_CPU*DATA_W-1:0] r_cpu_data;
  logic [N_CPU-1:0]        r_cpu_valid;
  logic [N_CPU-1:0]        w_can_accept;
  logic [N_MM-1:0]         w_eligible;
  logic [MM_W-1:0]         w_ptr;
  logic [MM_W:0]           w_scan;
  logic [MM_W-1:0]         w_grant_idx;
  logic                    w_found;
  logic                    w_grant_vld;
  logic [DATA_W-1:0]       w_sel_data;
  logic [CPU_W-1:0]        w_sel_dest;

  assign w_can_accept = ~r_cpu_valid | cpu_ready;

  // An out-of-range destination matches no CPU and so is never eligible.
  for (genvar i = 0; i < N_MM; i++) begin : g_mm
    logic [CPU_W-1:0] w_dest;
    logic             w_dest_free;
    assign w_dest = mm_dest[i*CPU_W +: CPU_W];
    always_comb begin
      w_dest_free = 1'b0;
      for (int j = 0; j < N_CPU; j++) begin
        if (w_dest == CPU_W'(j)) w_dest_free = w_can_accept[j];
      end
    end
    assign w_eligible[i] = mm_valid[i] & w_dest_free;
  end

  // Scan ptr, ptr+1, ... modulo N_MM; the first eligible index wins.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < N_MM; k++) begin
      w_scan = {1'b0, w_ptr} + (MM_W+1)'(k);
      if (w_scan >= (MM_W+1)'(N_MM)) w_scan = w_scan - (MM_W+1)'(N_MM);
      if (!w_found && w_eligible[w_scan[MM_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan[MM_W-1:0];
      end
    end
  end

  assign w_grant_vld = w_found & rst_n;
  assign w_sel_data  = mm_data[w_grant_idx*DATA_W +: DATA_W];
  assign w_sel_dest  = mm_dest[w_grant_idx*CPU_W +: CPU_W];

`ifdef XBAR_RR_EN
  logic [MM_W-1:0] r_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_vld) begin
      r_ptr <= (w_grant_idx == MM_W'(N_MM-1)) ? '0 : w_grant_idx + MM_W'(1);
    end
  end
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // Loading takes precedence over consuming, so a same-cycle reload keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_data  <= '0;
      r_cpu_valid <= '0;
    end else begin
      for (int j = 0; j < N_CPU; j++) begin
        if (w_grant_vld && (w_sel_dest == CPU_W'(j))) begin
          r_cpu_data[j*DATA_W +: DATA_W] <= w_sel_data;
          r_cpu_valid[j]                 <= 1'b1;
        end else if (cpu_ready[j]) begin
          r_cpu_data[j*DATA_W +: DATA_W] <= '0;
          r_cpu_valid[j]                 <= 1'b0;
        end
      end
    end
  end

  assign cpu_data  = r_cpu_data;
  assign cpu_valid = r_cpu_valid;
  assign grant_vld = w_grant_vld;
  assign grant     = w_grant_vld ? w_grant_idx : '0;
  assign mm_ready  = w_grant_vld ? (N_MM'(1) << w_grant_idx) : '0;

endmodule
`default_nettype wire

// File: tb/tb_crossbar_rr_nxm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_crossbar_rr_nxm
// Function : scoreboard bench for crossbar_rr_nxm (4x4 instance plus a 4x3
//            instance for out-of-range destinations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossbar_rr_nxm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mm_data;
  logic [7:0]  mm_dest;
  logic [3:0]  mm_valid;
  logic [3:0]  mm_ready;
  logic [31:0] cpu_data;
  logic [3:0]  cpu_valid;
  logic [3:0]  cpu_ready;
  logic [1:0]  grant;
  logic        grant_vld;

  logic [31:0] b_mm_data;
  logic [7:0]  b_mm_dest;
  logic [3:0]  b_mm_valid;
  logic [3:0]  b_mm_ready;
  logic [23:0] b_cpu_data;
  logic [2:0]  b_cpu_valid;
  logic [2:0]  b_cpu_ready;
  logic [1:0]  b_grant;
  logic        b_grant_vld;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       vld;
    logic [1:0] grant;
    logic [1:0] dest;
    logic [7:0] data;
    logic [3:0] cv;
  } exp_t;

  exp_t sb[$];
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  crossbar_rr_nxm #(.N_MM(4), .N_CPU(4), .DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mm_data(mm_data), .mm_dest(mm_dest),
    .mm_valid(mm_valid), .mm_ready(mm_ready), .cpu_data(cpu_data),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .grant(grant),
    .grant_vld(grant_vld)
  );

  crossbar_rr_nxm #(.N_MM(4), .N_CPU(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mm_data(b_mm_data), .mm_dest(b_mm_dest),
    .mm_valid(b_mm_valid), .mm_ready(b_mm_ready), .cpu_data(b_cpu_data),
    .cpu_valid(b_cpu_valid), .cpu_ready(b_cpu_ready), .grant(b_grant),
    .grant_vld(b_grant_vld)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic set_mm(input int i, input logic [7:0] d, input logic [1:0] dst);
    mm_data[i*8 +: 8] = d;
    mm_dest[i*2 +: 2] = dst;
  endtask

  // Drive one cycle of inputs and queue what the DUT must show during it.
  task automatic cyc(input logic [3:0] v, input logic [3:0] cr, input logic ev,
                     input logic [1:0] eg, input logic [3:0] ecv);
    exp_t e;
    mm_valid  = v;
    cpu_ready = cr;
    e.vld     = ev;
    e.grant   = eg;
    e.dest    = mm_dest[eg*2 +: 2];
    e.data    = mm_data[eg*8 +: 8];
    e.cv      = ecv;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares handshake outputs each cycle and the word landing in the
  // destination register one cycle after each grant.
  logic       pend = 1'b0;
  logic [1:0] pend_dest;
  logic [7:0] pend_data;
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] er;
    if (mon_en) begin
      if (pend) begin
        chk("load_data", {24'h0, cpu_data[pend_dest*8 +: 8]}, {24'h0, pend_data});
        chk("load_valid", {31'h0, cpu_valid[pend_dest]}, 32'h1);
        pend = 1'b0;
      end
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'h0, 32'h1);
      end else begin
        e  = sb.pop_front();
        er = e.vld ? (4'b0001 << e.grant) : 4'b0000;
        chk("grant_vld", {31'h0, grant_vld}, {31'h0, e.vld});
        chk("grant", {30'h0, grant}, e.vld ? {30'h0, e.grant} : 32'h0);
        chk("mm_ready", {28'h0, mm_ready}, {28'h0, er});
        chk("cpu_valid", {28'h0, cpu_valid}, {28'h0, e.cv});
        if (e.vld) begin
          pend      = 1'b1;
          pend_dest = e.dest;
          pend_data = e.data;
        end
      end
    end
  end

  task automatic do_reset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    mm_valid  = 4'h0;
    cpu_ready = 4'h0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    mm_valid    = 4'hF;
    mm_data     = $urandom;
    mm_dest     = 8'($urandom);
    cpu_ready   = 4'($urandom);
    b_mm_valid  = 4'h0;
    b_mm_data   = 32'h0;
    b_mm_dest   = 8'h0;
    b_cpu_ready = 3'h0;

    // Reset with live inputs: everything quiet.
    @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_valid", {28'h0, cpu_valid}, 32'h0);
    chk("rst_cpu_data", cpu_data, 32'h0);
    chk("rst_mm_ready", {28'h0, mm_ready}, 32'h0);
    chk("rst_grant_vld", {31'h0, grant_vld}, 32'h0);
    chk("rst_grant", {30'h0, grant}, 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    mm_data = 32'h0;
    mm_dest = 8'h0;

    // Idle, then single path MM2 -> CPU3.
    cyc(4'h0, 4'h0, 1'b0, 2'd0, 4'b0000);
    set_mm(2, 8'hA5, 2'd3);
    cyc(4'b0100, 4'h0, 1'b1, 2'd2, 4'b0000);
    cyc(4'h0, 4'h0, 1'b0, 2'd0, 4'b1000);
    cyc(4'h0, 4'h0, 1'b0, 2'd0, 4'b1000);
    chk("hold_data", cpu_data, 32'hA500_0000);
    cyc(4'h0, 4'b1000, 1'b0, 2'd0, 4'b1000);
    cyc(4'h0, 4'h0, 1'b0, 2'd0, 4'b0000);
    chk("idle_zero", cpu_data, 32'h0);

    // All four MMs eligible, all CPUs ready.
    do_reset();
    for (int i = 0; i < 4; i++) set_mm(i, 8'(8'h10 + i), 2'(i));
`ifdef XBAR_RR_EN
    cyc(4'hF, 4'hF, 1'b1, 2'd0, 4'b0000);
    cyc(4'hF, 4'hF, 1'b1, 2'd1, 4'b0001);
    cyc(4'hF, 4'hF, 1'b1, 2'd2, 4'b0010);
    cyc(4'hF, 4'hF, 1'b1, 2'd3, 4'b0100);
    cyc(4'hF, 4'hF, 1'b1, 2'd0, 4'b1000);
    cyc(4'hF, 4'hF, 1'b1, 2'd1, 4'b0001);
    cyc(4'h0, 4'hF, 1'b0, 2'd0, 4'b0010);
`else
    cyc(4'hF, 4'hF, 1'b1, 2'd0, 4'b0000);
    for (int i = 0; i < 5; i++) cyc(4'hF, 4'hF, 1'b1, 2'd0, 4'b0001);
    cyc(4'h0, 4'hF, 1'b0, 2'd0, 4'b0001);
`endif
    cyc(4'h0, 4'h0, 1'b0, 2'd0, 4'b0000);

    // Backpressure on CPU1, then same-cycle consume and reload.
    set_mm(3, 8'h77, 2'd1);
    cyc(4'b1000, 4'h0, 1'b1, 2'd3, 4'b0000);
    set_mm(0, 8'hB0, 2'd1);
    set_mm(1, 8'hB1, 2'd2);
    cyc(4'b0011, 4'h0, 1'b1, 2'd1, 4'b0010);
    cyc(4'b0001, 4'b0010, 1'b1, 2'd0, 4'b0110);
    cyc(4'h0, 4'b0110, 1'b0, 2'd0, 4'b0110);
    cyc(4'h0, 4'h0, 1'b0, 2'd0, 4'b0000);

    // Fill every CPU from MM0, then reset asynchronously between edges.
    for (int j = 0; j < 4; j++) begin
      set_mm(0, 8'(8'hC0 + j), 2'(j));
      cyc(4'b0001, 4'h0, 1'b1, 2'd0, 4'((1 << j) - 1));
    end
    cyc(4'h0, 4'h0, 1'b0, 2'd0, 4'b1111);
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) set_mm(i, 8'hEE, 2'd2);
    mm_valid = 4'hF;
    #2;
    chk("pre_areset_valid", {28'h0, cpu_valid}, 32'hF);
    chk("pre_areset_data", cpu_data, 32'hC3C2_C1C0);
    rst_n = 1'b0;
    #1;
    chk("areset_cpu_valid", {28'h0, cpu_valid}, 32'h0);
    chk("areset_cpu_data", cpu_data, 32'h0);
    chk("areset_mm_ready", {28'h0, mm_ready}, 32'h0);
    chk("areset_grant_vld", {31'h0, grant_vld}, 32'h0);
    @(posedge clk);
    #1;
    mm_valid = 4'h0;
    rst_n    = 1'b1;

    // Three CPUs: MM0 targets nonexistent CPU3 and must never win.
    b_mm_dest   = {2'd0, 2'd0, 2'd0, 2'd3};
    b_mm_data   = 32'h4433_2211;
    b_mm_valid  = 4'b0011;
    b_cpu_ready = 3'b111;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bad_grant_vld", {31'h0, b_grant_vld}, 32'h1);
      chk("bad_grant", {30'h0, b_grant}, 32'h1);
      chk("bad_mm_ready", {28'h0, b_mm_ready}, 32'h2);
      @(posedge clk);
      #1;
    end
    chk("bad_cpu0_data", {8'h0, b_cpu_data}, 32'h0000_0022);
    b_mm_valid = 4'b0001;
    @(negedge clk);
    chk("bad_alone_vld", {31'h0, b_grant_vld}, 32'h0);
    chk("bad_alone_ready", {28'h0, b_mm_ready}, 32'h0);

    chk("sb_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
